// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache front-end.
// Holds the controller state encoding, the line-offset geometry and small
// helpers that split a fetch address into index / tag / word-select fields
// and pick one instruction word out of a cache line.
package icache_pkg;

  localparam int ADDR_BITS     = 64;
  localparam int LINE_BITS     = 512;
  localparam int WORD_BITS     = 32;
  localparam int OFFSET_BITS   = 6;
  localparam int WORD_SEL_BITS = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    FILL      = 3'd4,
    RESP      = 3'd5
  } state_e;

  // Set index: the idx_bits directly above the line offset (zero-extended).
  function automatic logic [ADDR_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr,
                                                      input int idx_bits);
    return (addr >> OFFSET_BITS) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  // Tag: everything above the index field (zero-extended).
  function automatic logic [ADDR_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr,
                                                    input int idx_bits);
    return addr >> (OFFSET_BITS + idx_bits);
  endfunction

  // Word select within the line: addr[5:2].
  function automatic logic [WORD_SEL_BITS-1:0] addr_word_sel(input logic [ADDR_BITS-1:0] addr);
    return addr[OFFSET_BITS-1:2];
  endfunction

  // Word k of a line lives at bits [32k+31:32k].
  function automatic logic [WORD_BITS-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                     input logic [WORD_SEL_BITS-1:0] sel);
    return line[{sel, 5'b00000} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Line storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears valids only)
//   clear_all         synchronous invalidate of every set
//   rd_idx            combinational read index -> rd_valid / rd_tag / rd_data
//   wr_en, wr_idx,
//   wr_tag, wr_data   single write port; installs a line and marks it valid
module icache_line_store
  import icache_pkg::*;
#(
  parameter int SETS       = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 55,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_all,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [LINE_WIDTH-1:0] wr_data
);

  logic [SETS-1:0]       valid_q;
  logic [SETS-1:0]       valid_d;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [LINE_WIDTH-1:0] data_q [SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Next valid vector: clear-all beats a write (the two never coincide in use).
  always_comb begin
    valid_d = valid_q;
    if (clear_all) begin
      valid_d = {SETS{1'b0}};
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only state that must come out of reset known.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {SETS{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_line_fill.sv
// Direct-mapped instruction cache front-end fed by a 512-bit line fetcher.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   req_valid/req_addr/req_ready   fetch request handshake (one outstanding)
//   resp_valid/resp_insn/
//   resp_addr/resp_ready           instruction response, held until taken
//   flush                          invalidate all lines once back in IDLE
//   fill_enable/fill_addr          one-cycle start pulse + line address to fetcher
//   fill_ready/fill_data           completed line from fetcher
module icache_line_fill
  import icache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LINE_WIDTH     = 512,
  parameter int SETS           = 8,
  parameter int INSN_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [BUS_DATA_WIDTH-1:0] req_addr,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic [INSN_WIDTH-1:0]     resp_insn,
  output logic [BUS_DATA_WIDTH-1:0] resp_addr,
  input  logic                      resp_ready,
  input  logic                      flush,
  output logic                      fill_enable,
  output logic [BUS_DATA_WIDTH-1:0] fill_addr,
  input  logic                      fill_ready,
  input  logic [LINE_WIDTH-1:0]     fill_data
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = BUS_DATA_WIDTH - OFFSET_BITS - IDX_W;

  state_e                    state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
  logic                      flush_pend_q, flush_pend_d;
  logic                      blank_q, blank_d;
  logic                      req_ready_q, req_ready_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [INSN_WIDTH-1:0]     resp_insn_q, resp_insn_d;
  logic [BUS_DATA_WIDTH-1:0] resp_addr_q, resp_addr_d;
  logic                      fill_enable_q, fill_enable_d;
  logic [BUS_DATA_WIDTH-1:0] fill_addr_q, fill_addr_d;

  logic [IDX_W-1:0]          idx_s;
  logic [TAG_W-1:0]          tag_s;
  logic [WORD_SEL_BITS-1:0]  word_sel_s;
  logic                      rd_valid_s;
  logic [TAG_W-1:0]          rd_tag_s;
  logic [LINE_WIDTH-1:0]     rd_data_s;
  logic                      hit_s;
  logic                      flush_now_s;
  logic                      clear_all_s;
  logic                      wr_en_s;

  assign idx_s       = IDX_W'(addr_index(addr_q, IDX_W));
  assign tag_s       = TAG_W'(addr_tag(addr_q, IDX_W));
  assign word_sel_s  = addr_word_sel(addr_q);
  assign hit_s       = rd_valid_s && (rd_tag_s == tag_s);
  // A flush arriving together with a request must win, so it is honoured in
  // the same IDLE cycle rather than waiting for flush_pend to register.
  assign flush_now_s = flush_pend_q | flush;

  // req_ready is gated by a same-cycle flush so a flush+request cycle never
  // completes a handshake; the request is taken in the following cycle.
  assign req_ready   = req_ready_q & ~flush;
  assign resp_valid  = resp_valid_q;
  assign resp_insn   = resp_insn_q;
  assign resp_addr   = resp_addr_q;
  assign fill_enable = fill_enable_q;
  assign fill_addr   = fill_addr_q;

  icache_line_store #(
    .SETS      (SETS),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_WIDTH(LINE_WIDTH)
  ) u_store (
    .clk      (clk),
    .rst_n    (reset),
    .clear_all(clear_all_s),
    .rd_idx   (idx_s),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (wr_en_s),
    .wr_idx   (idx_s),
    .wr_tag   (tag_s),
    .wr_data  (fill_data)
  );

  // Controller next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    blank_d      = blank_q;
    resp_insn_d  = resp_insn_q;
    resp_addr_d  = resp_addr_q;
    flush_pend_d = flush_pend_q | flush;
    clear_all_s  = 1'b0;
    wr_en_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_now_s) begin
          clear_all_s  = 1'b1;
          flush_pend_d = 1'b0;
        end else if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          resp_insn_d = line_word(rd_data_s, word_sel_s);
          resp_addr_d = addr_q;
          state_d     = RESP;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        blank_d = 1'b1;
        state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        // First cycle ignores fill_ready: it may still be left over from the
        // previous fill.
        if (blank_q) begin
          blank_d = 1'b0;
        end else if (fill_ready) begin
          state_d = FILL;
        end else begin
          state_d = MISS_WAIT;
        end
      end
      FILL: begin
        wr_en_s     = 1'b1;
        resp_insn_d = line_word(fill_data, word_sel_s);
        resp_addr_d = addr_q;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_valid_q && resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // resp_valid rises one cycle after entering RESP and drops on handshake.
    resp_valid_d  = (state_q == RESP) && !(resp_valid_q && resp_ready);
    req_ready_d   = (state_d == IDLE) && !flush_pend_d;
    fill_enable_d = (state_d == MISS_REQ);
    fill_addr_d   = (state_d == MISS_REQ) ?
                    {addr_q[BUS_DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} :
                    fill_addr_q;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= {BUS_DATA_WIDTH{1'b0}};
      flush_pend_q  <= 1'b0;
      blank_q       <= 1'b0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_insn_q   <= {INSN_WIDTH{1'b0}};
      resp_addr_q   <= {BUS_DATA_WIDTH{1'b0}};
      fill_enable_q <= 1'b0;
      fill_addr_q   <= {BUS_DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      flush_pend_q  <= flush_pend_d;
      blank_q       <= blank_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_insn_q   <= resp_insn_d;
      resp_addr_q   <= resp_addr_d;
      fill_enable_q <= fill_enable_d;
      fill_addr_q   <= fill_addr_d;
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: directed scenarios followed by a
// randomized request stream, compared against a set-level cache model and a
// behavioural line fetcher that deliberately leaves fill_ready high between fills.
module tb_icache_line_fill;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [63:0]  req_addr = 64'd0;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_insn;
  logic [63:0]  resp_addr;
  logic         resp_ready = 1'b0;
  logic         flush = 1'b0;
  logic         fill_enable;
  logic [63:0]  fill_addr;
  logic         fill_ready = 1'b0;
  logic [511:0] fill_data = 512'd0;

  int checks = 0;
  int failures = 0;

  // Reference cache contents: which line each set holds.
  bit          m_valid [8];
  logic [63:0] m_tag   [8];

  // Fetcher model state.
  int          f_lat = 2;
  int          f_state = 0;
  int          f_cnt = 0;
  logic [63:0] f_addr = 64'd0;
  int          fills = 0;
  logic [63:0] last_fill_addr = 64'd0;

  icache_line_fill dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_insn  (resp_insn),
    .resp_addr  (resp_addr),
    .resp_ready (resp_ready),
    .flush      (flush),
    .fill_enable(fill_enable),
    .fill_addr  (fill_addr),
    .fill_ready (fill_ready),
    .fill_data  (fill_data)
  );

  always #5 clk = ~clk;

  // Backing memory: one distinct word per byte address (4-aligned).
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h1004) return 32'h00500093;
    return a[31:0] ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [511:0] mem_line(input logic [63:0] base);
    logic [511:0] l;
    l = 512'd0;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = mem_word(base + 64'(4*k));
    return l;
  endfunction

  // Fetcher: after a start pulse, keeps its old ready/data for two more
  // negedges (so the cache's blanking cycle sees a stale ready), then drops
  // ready, waits f_lat cycles and presents the new line, holding it afterwards.
  always @(negedge clk) begin
    if (!reset) begin
      fill_ready = 1'b0;
      f_state = 0;
    end else if (fill_enable) begin
      f_addr = fill_addr;
      last_fill_addr = fill_addr;
      fills++;
      f_cnt = f_lat;
      f_state = 1;
    end else if (f_state == 1) begin
      f_state = 2;
    end else if (f_state == 2) begin
      fill_ready = 1'b0;
      f_state = 3;
    end else if (f_state == 3) begin
      if (f_cnt == 0) begin
        fill_data = mem_line({f_addr[63:6], 6'd0});
        fill_ready = 1'b1;
        f_state = 0;
      end else begin
        f_cnt--;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   64'(req_ready),   64'd0);
    check({tag, "_resp_valid"},  64'(resp_valid),  64'd0);
    check({tag, "_fill_enable"}, 64'(fill_enable), 64'd0);
    check({tag, "_resp_insn"},   64'(resp_insn),   64'd0);
    check({tag, "_resp_addr"},   resp_addr,        64'd0);
    check({tag, "_fill_addr"},   fill_addr,        64'd0);
  endtask

  // Hold req_valid until accepted (bounded); returns at accept edge + 1.
  task automatic handshake(input logic [63:0] a);
    int n;
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // One full request: optional flush alongside the request or during it,
  // `hold` cycles of response backpressure, all checked against the model.
  task automatic do_req(input logic [63:0] a, input int hold, input bit flush_mid, input bit flush_with);
    int          idx;
    logic [63:0] tg;
    bit          miss;
    int          f0;
    int          n;
    idx = int'((a >> 6) % 64'd8);
    tg  = a >> 9;
    f0  = fills;
    if (flush_with) begin
      req_valid = 1'b1;
      req_addr  = a;
      flush = 1'b1;
      #1;
      check("flush_blocks_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      check("ready_after_flush", 64'(req_ready), 64'd1);
      model_clear();
    end
    miss = !(m_valid[idx] && m_tag[idx] == tg);
    handshake(a);
    flush = flush_mid;
    @(posedge clk); #1;
    flush = 1'b0;
    check("lat_edge1_idle", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    if (!miss) check("hit_lat_edge2", 64'(resp_valid), 64'd1);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_valid", 64'(resp_valid), 64'd1);
    check("fill_count", 64'(fills - f0), miss ? 64'd1 : 64'd0);
    if (miss) check("fill_addr", last_fill_addr, a & ~64'h3F);
    check("resp_insn", 64'(resp_insn), 64'(mem_word(a)));
    check("resp_addr", resp_addr, a);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_insn", 64'(resp_insn), 64'(mem_word(a)));
      check("hold_addr", resp_addr, a);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_drop", 64'(resp_valid), 64'd0);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (flush_mid) model_clear();
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int f0;
    model_clear();
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Cold miss with backpressure, then a hit in the same line.
    do_req(64'h1004, 5, 1'b0, 1'b0);
    do_req(64'h1008, 0, 1'b0, 1'b0);
    // Conflicting tags on set 0; each refill also sees a stale fill_ready.
    do_req(64'h1200, 1, 1'b0, 1'b0);
    do_req(64'h1000, 0, 1'b0, 1'b0);
    // Flush during a miss, refetch, then flush together with a request.
    f_lat = 3;
    do_req(64'h2000, 0, 1'b1, 1'b0);
    do_req(64'h2000, 0, 1'b0, 1'b0);
    do_req(64'h2004, 0, 1'b0, 1'b1);

    // Reset while the miss is waiting on the fetcher.
    f_lat = 8;
    f0 = fills;
    handshake(64'h3000);
    repeat (3) @(posedge clk);
    #1;
    check("midmiss_fill_issued", 64'(fills - f0), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midmiss");
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    f_lat = 1;
    do_req(64'h3000, 0, 1'b0, 1'b0);

    // Randomized stream over a small footprint to mix hits and conflicts.
    for (int i = 0; i < 40; i++) begin
      a = 64'h10000 + (64'($urandom_range(0, 2)) << 9) + (64'($urandom_range(0, 7)) << 6)
          + (64'($urandom_range(0, 15)) << 2);
      f_lat = int'($urandom_range(0, 3));
      do_req(a, int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
